// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types: FSM states, zero register, and the control bundle.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic pc_wr;
    logic pc_redirect;
    logic if_id_wr;
    logic id_ex_wr;
    logic ex_mem_wr;
    logic mem_wb_wr;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN    = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1,
                                  ex_mem_wr: 1'b1, mem_wb_wr: 1'b1, default: 1'b0};
  localparam ctl_t CTL_FREEZE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the pipeline and the stall/flush controls returned to it.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memr;
  logic [4:0] ex_rd;
  logic       mem_branch_taken;
  logic       mem_jump;
  logic       dmem_req;
  logic       dmem_ready;

  logic pc_wr, pc_redirect;
  logic if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
  logic if_id_flush, id_ex_flush, ex_mem_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memr, ex_rd,
           mem_branch_taken, mem_jump, dmem_req, dmem_ready,
    input  pc_wr, pc_redirect, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
           if_id_flush, id_ex_flush, ex_mem_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memr, ex_rd,
           mem_branch_taken, mem_jump, dmem_req, dmem_ready,
    output pc_wr, pc_redirect, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
           if_id_flush, id_ex_flush, ex_mem_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use, MEM redirect and data-memory wait
// hazards, memory timeout trap and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  ctl_t          ctl;
  logic          load_use, redirect, mwait, active;

  assign load_use = hz.ex_memr && (hz.ex_rd != ZERO_REG) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
  assign redirect = hz.mem_branch_taken | hz.mem_jump;
  assign mwait    = hz.dmem_req & ~hz.dmem_ready;
  assign active   = (state_q != ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // wait_q counts consecutive not-ready cycles already spent, so the trap
  // fires on the MEM_TIMEOUT-th one.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      RUN: if (mwait) begin
        state_d = MEM_WAIT;
        wait_d  = WW'(1);
      end
      MEM_WAIT: begin
        if (!mwait)                 state_d = RUN;
        else if (wait_q == WAIT_LAST) state_d = ERROR;
        else                        wait_d  = wait_q + 1'b1;
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctl = CTL_RUN;
    if (!active || mwait) begin
      ctl = CTL_FREEZE;
    end else if (redirect) begin
      ctl.pc_redirect  = 1'b1;
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_flush  = 1'b1;
      ctl.ex_mem_flush = 1'b1;
    end else if (load_use) begin
      ctl.pc_wr       = 1'b0;
      ctl.if_id_wr    = 1'b0;
      ctl.id_ex_flush = 1'b1;
    end
  end

  assign hz.pc_wr        = ctl.pc_wr;
  assign hz.pc_redirect  = ctl.pc_redirect;
  assign hz.if_id_wr     = ctl.if_id_wr;
  assign hz.id_ex_wr     = ctl.id_ex_wr;
  assign hz.ex_mem_wr    = ctl.ex_mem_wr;
  assign hz.mem_wb_wr    = ctl.mem_wb_wr;
  assign hz.if_id_flush  = ctl.if_id_flush;
  assign hz.id_ex_flush  = ctl.id_ex_flush;
  assign hz.ex_mem_flush = ctl.ex_mem_flush;
  assign err             = !active;

  // A load-use under a redirect is squashed with ID, so it is not a stall.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active && (mwait || (load_use && !redirect))),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active && redirect && !mwait),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: dut_a (default params) and dut_b (MEM_TIMEOUT=4, CNT_W=2) see the same stimulus.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       ex_memr;
    logic [4:0] ex_rd;
    logic       br;
    logic       jmp;
    logic       dreq;
    logic       drdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  // {pc_wr, pc_redirect, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_fl, id_ex_fl, ex_mem_fl}
  localparam logic [8:0] NONE  = 9'b1_0_1111_000;
  localparam logic [8:0] FRZ   = 9'b0_0_0000_000;
  localparam logic [8:0] REDIR = 9'b1_1_1111_111;
  localparam logic [8:0] LU    = 9'b0_0_0111_010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if ifa ();
  pipe_hazard_ctrl_if ifb ();

  logic        err_a, err_b;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  stall_b, flush_b;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .hz(ifa),
    .err(err_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .hz(ifb),
    .err(err_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  wire [8:0] ctl_a = {ifa.pc_wr, ifa.pc_redirect, ifa.if_id_wr, ifa.id_ex_wr, ifa.ex_mem_wr,
                      ifa.mem_wb_wr, ifa.if_id_flush, ifa.id_ex_flush, ifa.ex_mem_flush};
  wire [8:0] ctl_b = {ifb.pc_wr, ifb.pc_redirect, ifb.if_id_wr, ifb.id_ex_wr, ifb.ex_mem_wr,
                      ifb.mem_wb_wr, ifb.if_id_flush, ifb.id_ex_flush, ifb.ex_mem_flush};

  int checks = 0;
  int failures = 0;
  vec_t tbl [15];

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                             input logic m, input logic [4:0] rd, input logic br,
                             input logic j, input logic dq, input logic dr);
    in_t v;
    v = '{id_rs: rs, id_rt: rt, uses_rt: u, ex_memr: m, ex_rd: rd,
          br: br, jmp: j, dreq: dq, drdy: dr};
    return v;
  endfunction

  task automatic apply(input in_t v);
    ifa.id_rs = v.id_rs;   ifb.id_rs = v.id_rs;
    ifa.id_rt = v.id_rt;   ifb.id_rt = v.id_rt;
    ifa.id_uses_rt = v.uses_rt;      ifb.id_uses_rt = v.uses_rt;
    ifa.ex_memr = v.ex_memr;         ifb.ex_memr = v.ex_memr;
    ifa.ex_rd = v.ex_rd;             ifb.ex_rd = v.ex_rd;
    ifa.mem_branch_taken = v.br;     ifb.mem_branch_taken = v.br;
    ifa.mem_jump = v.jmp;            ifb.mem_jump = v.jmp;
    ifa.dmem_req = v.dreq;           ifb.dmem_req = v.dreq;
    ifa.dmem_ready = v.drdy;         ifb.dmem_ready = v.drdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  in_t idle, lu_in, mw_in;

  initial begin
    idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu_in = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    mw_in = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    tbl[0]  = '{idle, NONE};
    tbl[1]  = '{lu_in, LU};
    tbl[2]  = '{mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), NONE};
    tbl[3]  = '{mk(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), LU};
    tbl[4]  = '{mk(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), NONE};
    tbl[5]  = '{mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), NONE};
    tbl[6]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), REDIR};
    tbl[7]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), REDIR};
    tbl[8]  = '{mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), REDIR};
    tbl[9]  = '{mw_in, FRZ};
    tbl[10] = '{mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0), FRZ};
    tbl[11] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), NONE};
    tbl[12] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), NONE};
    tbl[13] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), REDIR};
    tbl[14] = '{mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1), LU};

    apply(idle);
    tick(); tick();
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_flush_a", 32'(flush_a), 32'd0);
    rst = 1'b0;

    // Combinational decode from RUN; idle cycle afterwards returns to RUN.
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].in);
      chk($sformatf("vec%0d_a", i), 32'(ctl_a), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_b", i), 32'(ctl_b), 32'(tbl[i].exp));
      tick();
      apply(idle);
      tick();
    end

    // Load-use then ex_rd=0, counters from reset.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("cnt_clr_stall", 32'(stall_a), 32'd0);
    apply(lu_in);
    chk("lu_ctl", 32'(ctl_a), 32'(LU));
    tick();
    chk("lu_stall", 32'(stall_a), 32'd1);
    apply(mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("lu_r0_stall", 32'(stall_a), 32'd1);

    // Taken branch, then branch with load-use.
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk("br_flush", 32'(flush_a), 32'd1);
    apply(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk("br_lu_flush", 32'(flush_a), 32'd2);
    chk("br_lu_stall", 32'(stall_a), 32'd1);

    // Three not-ready cycles, then ready.
    apply(mw_in);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mw%0d_ctl", i), 32'(ctl_a), 32'(FRZ));
      tick();
    end
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    chk("mw_done_ctl", 32'(ctl_a), 32'(NONE));
    tick();
    chk("mw_stall", 32'(stall_a), 32'd4);
    chk("mw_err_b", 32'(err_b), 32'd0);
    apply(idle);
    chk("mw_run_ctl", 32'(ctl_a), 32'(NONE));
    tick();

    // Wait with pending jump: frozen, then redirect on the ready cycle.
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wj%0d_ctl", i), 32'(ctl_a), 32'(FRZ));
      tick();
    end
    chk("wj_flush_hold", 32'(flush_a), 32'd2);
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1));
    chk("wj_ready_ctl", 32'(ctl_a), 32'(REDIR));
    tick();
    chk("wj_flush", 32'(flush_a), 32'd3);
    chk("wj_stall", 32'(stall_a), 32'd6);

    // Timeout on dut_b (MEM_TIMEOUT=4).
    apply(idle);
    rst = 1'b1; tick(); rst = 1'b0;
    apply(mw_in);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to%0d_err", i), 32'(err_b), 32'd0);
      tick();
    end
    chk("to_err_b", 32'(err_b), 32'd1);
    chk("to_err_a", 32'(err_a), 32'd0);
    chk("to_stall_b_sat", 32'(stall_b), 32'd3);
    chk("to_stall_a", 32'(stall_a), 32'd4);
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    chk("to_ctl_b", 32'(ctl_b), 32'(FRZ));
    tick();
    chk("to_sticky", 32'(err_b), 32'd1);
    apply(lu_in);
    tick();
    chk("to_nocount", 32'(stall_b), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("to_rst_err", 32'(err_b), 32'd0);
    chk("to_rst_cnt", 32'(stall_b), 32'd0);

    // Saturation: five load-use cycles.
    apply(lu_in);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_b", 32'(stall_b), 32'd3);
    chk("sat_a", 32'(stall_a), 32'd5);

    // Reset mid-wait, then a fresh 3-cycle wait must not trap dut_b.
    apply(mw_in);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_mw_ctl", 32'(ctl_b), 32'(FRZ));
    tick();
    rst = 1'b0;
    chk("rst_mw_cnt", 32'(stall_b), 32'd0);
    chk("rst_mw_err", 32'(err_b), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_mw_notrap", 32'(err_b), 32'd0);
    apply(idle);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
